// File: rtl/midi_tx_if.sv
// FIFO-side handshake between an upstream byte FIFO and the MIDI transmitter.
// The master drives occupancy and head byte; the slave returns the pop strobe.
interface midi_tx_if;
  logic       fifo_empty;
  logic [7:0] data_i;
  logic       stb_rd;

  modport master (
    output fifo_empty,
    output data_i,
    input  stb_rd
  );

  modport slave (
    input  fifo_empty,
    input  data_i,
    output stb_rd
  );
endinterface

// File: rtl/midi_tx.sv
// MIDI serial transmitter: pops bytes from a FIFO and sends 8N1 frames, CLK_DIV clocks per bit.
// Optional running-status suppression is compiled in with `define MIDI_TX_RUNNING_STATUS_EN.
module midi_tx #(
  parameter int unsigned CLK_DIV = 32
) (
  input  logic       clk,
  input  logic       reset,
  midi_tx_if.slave   fifo,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              pop_c;
  logic              suppress_c;
  logic              baud_done_c;

  assign baud_done_c = (cnt_q == CNT_LAST);

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic              rs_valid_q, rs_valid_d;
  logic [DATA_W-1:0] rs_byte_q, rs_byte_d;
  logic              is_chan_c;
  logic              is_sys_common_c;

  // Channel status 0x80..0xEF may be elided; 0xF0..0xF7 cancels running status.
  assign is_chan_c       = (fifo.data_i >= 8'h80) && (fifo.data_i <= 8'hEF);
  assign is_sys_common_c = (fifo.data_i[7:3] == 5'b11110);
  assign suppress_c      = is_chan_c && rs_valid_q && (fifo.data_i == rs_byte_q);

  always_comb begin
    rs_valid_d = rs_valid_q;
    rs_byte_d  = rs_byte_q;
    if (pop_c && !suppress_c) begin
      if (is_chan_c) begin
        rs_valid_d = 1'b1;
        rs_byte_d  = fifo.data_i;
      end else if (is_sys_common_c) begin
        rs_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_valid_q <= 1'b0;
      rs_byte_q  <= '0;
    end else begin
      rs_valid_q <= rs_valid_d;
      rs_byte_q  <= rs_byte_d;
    end
  end
`else
  assign suppress_c = 1'b0;
`endif

  // Next-state logic; tx/busy are derived from the next state so they register with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!fifo.fifo_empty) begin
          pop_c = 1'b1;
          if (!suppress_c) begin
            shift_d = fifo.data_i;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        if (baud_done_c) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_done_c) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_done_c) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Pop strobe is a same-cycle acknowledge of the FIFO head, masked during reset.
  assign fifo.stb_rd = pop_c && !reset;
  assign tx          = tx_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx at CLK_DIV=4 with a queue-backed FIFO model.
// Builds with or without MIDI_TX_RUNNING_STATUS_EN.
module tb_midi_tx;

  localparam int DIV    = 4;
  localparam int FRAME  = 10 * DIV;
  localparam int PERIOD = FRAME + 1;

  typedef logic [7:0] byte_q_t [$];

  logic clk;
  logic reset;
  logic tx;
  logic busy;

  midi_tx_if fif();

  midi_tx #(.CLK_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .fifo  (fif),
    .tx    (tx),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifoq[$];
  logic       tx_log[$];
  logic       busy_log[$];
  logic       stb_log[$];
  int         starts[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fif.fifo_empty = (fifoq.size() == 0);
    fif.data_i     = (fifoq.size() != 0) ? fifoq[0] : 8'h00;
  endtask

  // One clock: sample at negedge, let the edge happen, then update the FIFO model.
  task automatic cyc();
    logic s;
    @(negedge clk);
    s = fif.stb_rd;
    tx_log.push_back(tx);
    busy_log.push_back(busy);
    stb_log.push_back(s);
    check("stb_guard", 32'(s & (fif.fifo_empty | reset)), 32'd0);
    @(posedge clk);
    #1;
    if (s && fifoq.size() != 0) fifoq.delete(0);
    drive_fifo();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    check("rst_tx",   32'(tx_log[tx_log.size()-1]),     32'd1);
    check("rst_busy", 32'(busy_log[busy_log.size()-1]), 32'd0);
    check("rst_stb",  32'(stb_log[stb_log.size()-1]),   32'd0);
    reset = 1'b0;
  endtask

  function automatic int count_stb(input int from, input int to);
    int n = 0;
    for (int i = from; i < to; i++) if (stb_log[i]) n++;
    return n;
  endfunction

  task automatic find_starts(input int from);
    starts.delete();
    for (int i = from + 1; i < busy_log.size(); i++)
      if (busy_log[i] && !busy_log[i-1]) starts.push_back(i);
  endtask

  // p is the pop cycle; the frame occupies p+1 .. p+FRAME.
  task automatic check_frame(input int p, input logic [7:0] b);
    logic e;
    if (p < 0 || p + FRAME + 1 >= tx_log.size()) begin
      check("frame_window", 32'd0, 32'd1);
      return;
    end
    check($sformatf("f%02h_busy_pre", b), 32'(busy_log[p]), 32'd0);
    for (int k = 0; k < FRAME; k++) begin
      if (k < DIV)          e = 1'b0;
      else if (k < 9 * DIV) e = b[(k - DIV) / DIV];
      else                  e = 1'b1;
      check($sformatf("f%02h_tx_k%0d", b, k),   32'(tx_log[p+1+k]),   32'(e));
      check($sformatf("f%02h_busy_k%0d", b, k), 32'(busy_log[p+1+k]), 32'd1);
    end
    check($sformatf("f%02h_busy_post", b), 32'(busy_log[p+FRAME+1]), 32'd0);
  endtask

  task automatic stream_test(input string tag, input byte_q_t in, input byte_q_t exp,
                             input bit spacing);
    int base;
    int n;
    do_reset();
    base = tx_log.size();
    foreach (in[i]) fifoq.push_back(in[i]);
    drive_fifo();
    run(in.size() * PERIOD + 10);
    check({tag, "_stb_count"}, 32'(count_stb(base, tx_log.size())), 32'(in.size()));
    find_starts(base);
    check({tag, "_frames"}, 32'(starts.size()), 32'(exp.size()));
    n = (starts.size() < exp.size()) ? starts.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      check_frame(starts[i] - 1, exp[i]);
      if (spacing && i > 0)
        check($sformatf("%s_gap%0d", tag, i), 32'(starts[i] - starts[i-1]), 32'(PERIOD));
    end
    check({tag, "_drained"}, 32'(fifoq.size()), 32'd0);
  endtask

  task automatic reset_abort_test();
    int n;
    int base;
    do_reset();
    fifoq.push_back(8'h55);
    fifoq.push_back(8'h12);
    drive_fifo();
    n = 0;
    do begin
      cyc();
      n++;
    end while (!stb_log[stb_log.size()-1] && n < 20);
    check("abort_pop_seen", 32'(stb_log[stb_log.size()-1]), 32'd1);
    run(14);
    check("abort_midframe_busy", 32'(busy_log[busy_log.size()-1]), 32'd1);
    reset = 1'b1;
    cyc();
    cyc();
    check("abort_tx",   32'(tx_log[tx_log.size()-1]),   32'd1);
    check("abort_busy", 32'(busy_log[busy_log.size()-1]), 32'd0);
    run(3);
    check("abort_no_pop", 32'(fifoq.size()), 32'd1);
    reset = 1'b0;
    base = tx_log.size();
    run(PERIOD + 10);
    check("abort_stb_count", 32'(count_stb(base, tx_log.size())), 32'd1);
    find_starts(base);
    check("abort_frames", 32'(starts.size()), 32'd1);
    if (starts.size() != 0) check_frame(starts[0] - 1, 8'h12);
  endtask

  initial begin
    reset          = 1'b1;
    fif.fifo_empty = 1'b1;
    fif.data_i     = 8'h00;

    stream_test("single", '{8'h90}, '{8'h90}, 1'b1);
    stream_test("three",  '{8'h90, 8'h3C, 8'h7F}, '{8'h90, 8'h3C, 8'h7F}, 1'b1);
    reset_abort_test();
`ifdef MIDI_TX_RUNNING_STATUS_EN
    stream_test("rs",    '{8'h90, 8'h3C, 8'h7F, 8'h90, 8'h40, 8'h7F},
                         '{8'h90, 8'h3C, 8'h7F, 8'h40, 8'h7F}, 1'b0);
    stream_test("rs_f8", '{8'h90, 8'h3C, 8'h7F, 8'hF8, 8'h90, 8'h40},
                         '{8'h90, 8'h3C, 8'h7F, 8'hF8, 8'h40}, 1'b0);
    stream_test("rs_f0", '{8'h90, 8'h3C, 8'h7F, 8'hF0, 8'h90, 8'h40},
                         '{8'h90, 8'h3C, 8'h7F, 8'hF0, 8'h90, 8'h40}, 1'b1);
`else
    stream_test("plain", '{8'h90, 8'h3C, 8'h7F, 8'h90, 8'h40, 8'h7F},
                         '{8'h90, 8'h3C, 8'h7F, 8'h90, 8'h40, 8'h7F}, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_tx.md
MIDI_TX -- requirements
Module: midi_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 32, meaning clk cycles per MIDI bit (32 at 1 MHz clk gives 31250 baud); legal range 2..65535.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all logic.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port fifo_empty  input  1  high when the upstream output FIFO holds no byte.
REQ-005 The block SHALL have port data_i  input  8  FIFO head byte, valid whenever fifo_empty is low.
REQ-006 The block SHALL have port stb_rd  output  1  one-cycle pop strobe to the FIFO.
REQ-007 The block SHALL have port tx  output  1  MIDI serial line, idle high.
REQ-008 The block SHALL have port busy  output  1  high while a frame is on the line.

Function
REQ-009 The block SHALL implement states IDLE, START, DATA, STOP.
REQ-010 In IDLE with fifo_empty low, the block SHALL assert stb_rd for exactly that cycle, latch data_i into the shift register on that edge, and enter START.
REQ-011 In IDLE with fifo_empty high, the block SHALL hold stb_rd=0, tx=1, busy=0.
REQ-012 The block SHALL never assert stb_rd while fifo_empty is high or outside IDLE.
REQ-013 START SHALL drive tx=0 for CLK_DIV cycles, then enter DATA.
REQ-014 DATA SHALL drive the 8 latched bits LSB first, CLK_DIV cycles each, using a 3-bit bit counter, then enter STOP.
REQ-015 STOP SHALL drive tx=1 for CLK_DIV cycles, then return to IDLE.
REQ-016 The baud counter SHALL be 16 bits wide, count 0..CLK_DIV-1, and reload at 0 on every state entry.
REQ-017 tx SHALL be registered; the first START cycle on tx SHALL be the cycle after the stb_rd cycle.
REQ-018 A frame SHALL be exactly 10*CLK_DIV cycles; back-to-back bytes SHALL start every 10*CLK_DIV+1 cycles (one IDLE cycle between frames).
REQ-019 busy SHALL be high exactly while in START, DATA or STOP.
REQ-020 Changes on data_i or fifo_empty during a frame SHALL not affect the frame in progress.

Reset
REQ-021 While reset is high, the block SHALL force state IDLE, tx=1, stb_rd=0, busy=0, clear counters and the shift register, and clear the running-status register (when compiled).
REQ-022 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 from the cycle after the reset edge; the aborted byte SHALL not be retransmitted.
REQ-023 After reset deasserts, the block SHALL issue the first stb_rd no earlier than the first cycle with reset low and fifo_empty low.

Configuration
REQ-024 When MIDI_TX_RUNNING_STATUS_EN is defined, the block SHALL keep a last-status register (valid flag plus 8 bits).
REQ-025 With MIDI_TX_RUNNING_STATUS_EN, a channel status byte (0x80..0xEF) equal to the stored status SHALL be popped (one stb_rd) without sending a frame; the block SHALL stay in IDLE and may pop again the next cycle.
REQ-026 With MIDI_TX_RUNNING_STATUS_EN, a transmitted 0x80..0xEF byte SHALL update the stored status.
REQ-027 With MIDI_TX_RUNNING_STATUS_EN, 0xF0..0xF7 SHALL be transmitted and clear the valid flag.
REQ-028 With MIDI_TX_RUNNING_STATUS_EN, 0xF8..0xFF and data bytes (0x00..0x7F) SHALL be transmitted and leave the stored status unchanged.
REQ-029 Without MIDI_TX_RUNNING_STATUS_EN, every popped byte SHALL be transmitted and no status register SHALL exist.

Verification
REQ-030 CLK_DIV=4, push 0x90 -> stb_rd pulse 1 cycle, tx low 4 cycles, then bits 0,0,0,0,1,0,0,1 at 4 cycles each, high 4 cycles; busy high 40 cycles.
REQ-031 CLK_DIV=4, FIFO holds 0x90,0x3C,0x7F -> three frames, start edges 41 cycles apart, exactly three stb_rd pulses.
REQ-032 CLK_DIV=4, reset asserted at cycle 15 of a 0x55 frame -> tx=1, busy=0 next cycle; FIFO not popped again until reset low.
REQ-033 RUNNING_STATUS_EN, stream 0x90,0x3C,0x7F,0x90,0x40,0x7F -> five frames (second 0x90 popped, not sent); no stb_rd while fifo_empty high.
REQ-034 RUNNING_STATUS_EN, stream 0x90,0x3C,0x7F,0xF8,0x90,0x40 -> 0xF8 sent, second 0x90 suppressed; with 0xF0 in place of 0xF8, second 0x90 sent.
REQ-035 Macro undefined, same stream as REQ-033 -> six frames, six stb_rd pulses.
